id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register sitting directly downstream of the register-file read in the decode stage.
- Captures the two register operands, the sign-extended immediate, the register addresses and the decode control bits each cycle, and presents them to the EX stage.
- Contains the load-use hazard detector: it stalls IF/ID and injects a bubble when a load in EX feeds the instruction in ID.
- Also supports branch flush, downstream hold and a stall-cycle performance counter.

Parameters:
- DW, 32, operand/immediate/PC width
- AW, 5, register address width
- CW, 32, stall counter width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset
- id_valid  in  1  decode slot holds a real instruction
- id_rs, id_rt, id_rd  in  AW each  source/dest register numbers from decode
- id_uses_rs, id_uses_rt  in  1 each  instruction actually reads rs/rt
- id_data1, id_data2  in  DW each  register-file read data for rs/rt (WB bypass already applied upstream)
- id_imm  in  DW  sign-extended immediate
- id_pc4  in  DW  PC+4 of the decoded instruction
- id_ctl  in  10  {regwrite, memread, memwrite, memtoreg, alusrc, regdst, aluop[3:0]}
- flush  in  1  branch/jump resolved taken in EX; discard the ID instruction
- hold  in  1  downstream (MEM) not ready; freeze ID/EX
- ex_valid, ex_rs, ex_rt, ex_rd, ex_data1, ex_data2, ex_imm, ex_pc4, ex_ctl  out  widths as inputs  registered EX-stage copies
- stall  out  1  combinational; IF/ID and PC must not advance this cycle
- stall_cnt  out  CW  count of load-use bubble cycles

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset (rst=1 at posedge): every ex_* output is cleared to 0, including ex_valid and all ex_ctl bits, and stall_cnt is cleared to 0. Reset wins over every other input. A reset asserted mid-stall clears the stage; stall then follows its combinational equation on the cleared state, giving 0.
- Load-use detect:
  - lu = id_valid & ex_valid & ex_ctl.memread & (ex_rt != 0) & ((id_uses_rs & id_rs == ex_rt) | (id_uses_rt & id_rt == ex_rt)).
  - A match on register 0 never stalls.
- stall = (lu & ~flush) | hold. Purely combinational, no added latency.
- Register update priority at each posedge, rst=0:
  1. hold=1: all ex_* registers keep their values, whatever flush or lu are. flush during hold has no effect on ID/EX; the flush source must hold its request until hold drops.
  2. flush=1: load a bubble — ex_valid=0, ex_ctl=0; other ex_* fields don't-care but are cleared to 0.
  3. lu=1: load a bubble exactly as in 2. IF/ID holds, so the same instruction re-presents next cycle. The load has then moved to MEM, lu drops, and the instruction loads normally. Net penalty is exactly 1 bubble per load-use pair.
  4. Otherwise: load all id_* inputs. ex_valid <= id_valid. If id_valid=0, ex_ctl is loaded as 0, so invalid slots never write state.
- Latency: 1 cycle from ID inputs to ex_* outputs.
- stall_cnt:
  - Increments by 1 on each posedge where case 3 is taken.
  - Does not count hold or flush cycles.
  - Saturates at all-ones, with no wrap.
- Both rs and rt hazards on the same load are one event: one bubble, one count.
- Width rules: no arithmetic besides the counter. Address compares are full AW bits.

Test Plan:
- Reset: drive rst=1 for 2 cycles with nonzero id_* inputs -> all ex_* = 0, stall_cnt = 0, stall = 0.
- Straight-line: load id_rs=3, id_data1=0x11, id_imm=0xFFFFFFF0, ctl regwrite+alusrc, with no hazards -> next cycle ex_data1=0x11, ex_imm=0xFFFFFFF0, ex_valid=1; stall stays 0.
- Load-use:
  - EX holds lw with ex_rt=8. ID presents an add with id_rs=8, id_uses_rs=1 -> stall=1 that cycle; next cycle ex_valid=0 and ex_ctl=0.
  - The cycle after, the add loads into EX. stall_cnt = 1.
- No false stall:
  - Same lw with ex_rt=8, but id_uses_rs=0, or id_rs=9 -> stall=0, no bubble.
  - lw with ex_rt=0 and id_rs=0 -> stall=0.
- Flush vs load-use: flush=1 together with lu=1 -> stall=0, bubble inserted, stall_cnt unchanged.
- Hold: hold=1 for 3 cycles while ID inputs change, with flush pulsed in cycle 2 -> ex_* unchanged for all 3 cycles, stall=1 throughout. Preload stall_cnt to all-ones via a long test -> it stays all-ones after a further load-use.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush,
// downstream hold and a saturating count of load-use bubble cycles.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic [AW-1:0] id_rd,
    input  logic          id_uses_rs,
    input  logic          id_uses_rt,
    input  logic [DW-1:0] id_data1,
    input  logic [DW-1:0] id_data2,
    input  logic [DW-1:0] id_imm,
    input  logic [DW-1:0] id_pc4,
    input  logic [9:0]    id_ctl,

    input  logic          flush,
    input  logic          hold,

    output logic          ex_valid,
    output logic [AW-1:0] ex_rs,
    output logic [AW-1:0] ex_rt,
    output logic [AW-1:0] ex_rd,
    output logic [DW-1:0] ex_data1,
    output logic [DW-1:0] ex_data2,
    output logic [DW-1:0] ex_imm,
    output logic [DW-1:0] ex_pc4,
    output logic [9:0]    ex_ctl,

    output logic          stall,
    output logic [CW-1:0] stall_cnt
);

    // ctl layout: {regwrite, memread, memwrite, memtoreg, alusrc, regdst, aluop[3:0]}
    localparam int CTL_MEMREAD = 8;

    logic ex_memread;
    logic rs_hit;
    logic rt_hit;
    logic lu;
    logic bubble;
    logic count_en;
    logic cnt_sat;

    always_comb begin
        ex_memread = ex_ctl[CTL_MEMREAD];
        rs_hit     = id_uses_rs && (id_rs == ex_rt);
        rt_hit     = id_uses_rt && (id_rt == ex_rt);
        // A load targeting r0 never produces a value worth waiting for.
        lu         = id_valid && ex_valid && ex_memread && (ex_rt != '0) && (rs_hit || rt_hit);
        stall      = (lu && !flush) || hold;
        bubble     = flush || lu;
        count_en   = !hold && !flush && lu;
        cnt_sat    = (stall_cnt == {CW{1'b1}});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_rd    <= '0;
            ex_data1 <= '0;
            ex_data2 <= '0;
            ex_imm   <= '0;
            ex_pc4   <= '0;
            ex_ctl   <= '0;
        end else if (!hold) begin
            if (bubble) begin
                ex_valid <= 1'b0;
                ex_rs    <= '0;
                ex_rt    <= '0;
                ex_rd    <= '0;
                ex_data1 <= '0;
                ex_data2 <= '0;
                ex_imm   <= '0;
                ex_pc4   <= '0;
                ex_ctl   <= '0;
            end else begin
                ex_valid <= id_valid;
                ex_rs    <= id_rs;
                ex_rt    <= id_rt;
                ex_rd    <= id_rd;
                ex_data1 <= id_data1;
                ex_data2 <= id_data2;
                ex_imm   <= id_imm;
                ex_pc4   <= id_pc4;
                // Invalid slots carry no control so they can never write state.
                ex_ctl   <= id_valid ? id_ctl : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (count_en && !cnt_sat) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Table-driven bench for id_ex_stage: expected EX-stage contents are queued
// when each vector is driven and compared one clock later.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    localparam logic [9:0] CTL_LW   = 10'h360;
    localparam logic [9:0] CTL_ADD  = 10'h212;
    localparam logic [9:0] CTL_ADDI = 10'h220;

    typedef enum logic [1:0] {ACT_LOAD, ACT_BUBBLE, ACT_KEEP, ACT_ZERO} act_t;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] rd;
        logic          uses_rs;
        logic          uses_rt;
        logic [DW-1:0] data1;
        logic [DW-1:0] data2;
        logic [DW-1:0] imm;
        logic [DW-1:0] pc4;
        logic [9:0]    ctl;
    } in_t;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] rd;
        logic [DW-1:0] data1;
        logic [DW-1:0] data2;
        logic [DW-1:0] imm;
        logic [DW-1:0] pc4;
        logic [9:0]    ctl;
        logic [CW-1:0] cnt;
    } out_t;

    typedef struct {
        logic          rst;
        in_t           in;
        logic          flush;
        logic          hold;
        logic          chk_stall;
        logic          exp_stall;
        act_t          act;
        logic [CW-1:0] exp_cnt;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          id_valid;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic          id_uses_rs, id_uses_rt;
    logic [DW-1:0] id_data1, id_data2, id_imm, id_pc4;
    logic [9:0]    id_ctl;
    logic          flush, hold;
    logic          ex_valid;
    logic [AW-1:0] ex_rs, ex_rt, ex_rd;
    logic [DW-1:0] ex_data1, ex_data2, ex_imm, ex_pc4;
    logic [9:0]    ex_ctl;
    logic          stall;
    logic [CW-1:0] stall_cnt;

    id_ex_stage #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_data1(id_data1), .id_data2(id_data2), .id_imm(id_imm), .id_pc4(id_pc4),
        .id_ctl(id_ctl), .flush(flush), .hold(hold),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
        .ex_ctl(ex_ctl), .stall(stall), .stall_cnt(stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    vec_t vecs[$];
    out_t sb[$];
    out_t last_exp;
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic in_t mk_in(input logic v, input int rs, input int rt, input int rd,
                                  input logic urs, input logic urt, input logic [9:0] ctl,
                                  input int tag);
        in_t r;
        r.valid   = v;
        r.rs      = AW'(rs);
        r.rt      = AW'(rt);
        r.rd      = AW'(rd);
        r.uses_rs = urs;
        r.uses_rt = urt;
        r.data1   = 32'hA000_0000 | 32'(tag);
        r.data2   = 32'h5000_0000 | 32'(tag);
        r.imm     = 32'hFFFF_FF00 | 32'(tag);
        r.pc4     = 32'(tag) << 2;
        r.ctl     = ctl;
        return r;
    endfunction

    task automatic add_vec(input logic r, input in_t in, input logic f, input logic h,
                           input logic chk, input logic st, input act_t act, input int cnt);
        vec_t v;
        v.rst = r; v.in = in; v.flush = f; v.hold = h;
        v.chk_stall = chk; v.exp_stall = st; v.act = act; v.exp_cnt = CW'(cnt);
        vecs.push_back(v);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        out_t e, a;
        rst = v.rst; flush = v.flush; hold = v.hold;
        id_valid = v.in.valid; id_rs = v.in.rs; id_rt = v.in.rt; id_rd = v.in.rd;
        id_uses_rs = v.in.uses_rs; id_uses_rt = v.in.uses_rt;
        id_data1 = v.in.data1; id_data2 = v.in.data2; id_imm = v.in.imm;
        id_pc4 = v.in.pc4; id_ctl = v.in.ctl;
        #1;
        if (v.chk_stall) begin
            n_checks++;
            if (stall === v.exp_stall) n_pass++;
            else $display("FAIL vec%0d stall: got %b want %b", idx, stall, v.exp_stall);
        end
        case (v.act)
            ACT_LOAD: begin
                e.valid = v.in.valid; e.rs = v.in.rs; e.rt = v.in.rt; e.rd = v.in.rd;
                e.data1 = v.in.data1; e.data2 = v.in.data2; e.imm = v.in.imm;
                e.pc4 = v.in.pc4; e.ctl = v.in.valid ? v.in.ctl : 10'h0;
            end
            ACT_KEEP: e = last_exp;
            default:  e = '0;
        endcase
        e.cnt = v.exp_cnt;
        last_exp = e;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        a = {ex_valid, ex_rs, ex_rt, ex_rd, ex_data1, ex_data2, ex_imm, ex_pc4, ex_ctl, stall_cnt};
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL vec%0d ex_regs: got v=%b ctl=%h rs=%0d rt=%0d rd=%0d d1=%h d2=%h imm=%h pc4=%h cnt=%0d want v=%b ctl=%h rs=%0d rt=%0d rd=%0d d1=%h d2=%h imm=%h pc4=%h cnt=%0d",
                      idx, a.valid, a.ctl, a.rs, a.rt, a.rd, a.data1, a.data2, a.imm, a.pc4, a.cnt,
                      e.valid, e.ctl, e.rs, e.rt, e.rd, e.data1, e.data2, e.imm, e.pc4, e.cnt);
    endtask

    initial begin
        in_t lw8, add8, straight;
        lw8  = mk_in(1, 2, 8, 0, 1, 0, CTL_LW, 'h30);
        add8 = mk_in(1, 8, 9, 10, 1, 1, CTL_ADD, 'h31);
        straight = mk_in(1, 3, 4, 5, 1, 0, CTL_ADDI, 0);
        straight.data1 = 32'h11; straight.data2 = 32'h22;
        straight.imm = 32'hFFFF_FFF0; straight.pc4 = 32'h104;

        // Reset with live-looking inputs, then straight-line and load-use cases.
        add_vec(1, lw8, 0, 0, 0, 0, ACT_ZERO, 0);
        add_vec(1, add8, 0, 0, 1, 0, ACT_ZERO, 0);
        add_vec(0, straight, 0, 0, 1, 0, ACT_LOAD, 0);
        add_vec(0, lw8, 0, 0, 1, 0, ACT_LOAD, 0);
        add_vec(0, add8, 0, 0, 1, 1, ACT_BUBBLE, 1);
        add_vec(0, add8, 0, 0, 1, 0, ACT_LOAD, 1);
        add_vec(0, lw8, 0, 0, 1, 0, ACT_LOAD, 1);
        add_vec(0, mk_in(1, 8, 9, 10, 0, 1, CTL_ADD, 'h40), 0, 0, 1, 0, ACT_LOAD, 1);
        add_vec(0, lw8, 0, 0, 1, 0, ACT_LOAD, 1);
        add_vec(0, mk_in(1, 9, 7, 10, 1, 1, CTL_ADD, 'h41), 0, 0, 1, 0, ACT_LOAD, 1);
        add_vec(0, mk_in(1, 1, 0, 0, 1, 0, CTL_LW, 'h42), 0, 0, 1, 0, ACT_LOAD, 1);
        add_vec(0, mk_in(1, 0, 8, 0, 1, 0, CTL_LW, 'h43), 0, 0, 1, 0, ACT_LOAD, 1);
        add_vec(0, add8, 1, 0, 1, 0, ACT_BUBBLE, 1);
        add_vec(0, lw8, 0, 0, 1, 0, ACT_LOAD, 1);
        add_vec(0, mk_in(1, 8, 8, 11, 1, 1, CTL_ADD, 'h44), 0, 0, 1, 1, ACT_BUBBLE, 2);
        add_vec(0, mk_in(1, 8, 8, 11, 1, 1, CTL_ADD, 'h44), 0, 0, 1, 0, ACT_LOAD, 2);
        // Hold for three cycles with changing inputs and a flush pulse.
        add_vec(0, lw8, 0, 1, 1, 1, ACT_KEEP, 2);
        add_vec(0, mk_in(1, 6, 7, 12, 1, 1, CTL_ADD, 'h50), 1, 1, 1, 1, ACT_KEEP, 2);
        add_vec(0, mk_in(1, 13, 14, 15, 1, 1, CTL_ADDI, 'h51), 0, 1, 1, 1, ACT_KEEP, 2);
        add_vec(0, mk_in(0, 3, 4, 5, 1, 1, CTL_ADD, 'h52), 0, 0, 1, 0, ACT_LOAD, 2);
        // Hold takes precedence over a pending load-use bubble.
        add_vec(0, lw8, 0, 0, 1, 0, ACT_LOAD, 2);
        add_vec(0, add8, 0, 1, 1, 1, ACT_KEEP, 2);
        add_vec(0, add8, 0, 0, 1, 1, ACT_BUBBLE, 3);
        add_vec(0, add8, 0, 0, 1, 0, ACT_LOAD, 3);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Drive the counter into saturation and beyond.
        for (int k = 1; k <= 14; k++) begin
            vec_t v;
            int   c;
            c = (3 + k > 15) ? 15 : 3 + k;
            v = '{0, lw8, 0, 0, 1, 0, ACT_LOAD, CW'((3 + k - 1 > 15) ? 15 : 3 + k - 1)};
            run_vec(v, 100 + 3 * k);
            v = '{0, add8, 0, 0, 1, 1, ACT_BUBBLE, CW'(c)};
            run_vec(v, 101 + 3 * k);
            v = '{0, add8, 0, 0, 1, 0, ACT_LOAD, CW'(c)};
            run_vec(v, 102 + 3 * k);
        end

        // Reset arriving while a load-use stall is active.
        begin
            vec_t v;
            v = '{0, lw8, 0, 0, 1, 0, ACT_LOAD, CW'(15)};
            run_vec(v, 200);
            v = '{1, add8, 0, 0, 1, 1, ACT_ZERO, CW'(0)};
            run_vec(v, 201);
            v = '{0, add8, 0, 0, 1, 0, ACT_LOAD, CW'(0)};
            run_vec(v, 202);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
